// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding an in-order prefetch queue.
// Redirects flush the queue; a response still in flight after a redirect is drained and dropped.
module fetch_unit #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [WIDTH-1:0] imem_resp_data,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr,
  input  logic             if_ready,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid && ready at the rising edge.
  // imem_req_valid never depends on imem_req_ready; if_valid never depends on if_ready.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q;
  logic [WIDTH-1:0] req_pc_q;
  logic [CW-1:0]    occ_q;
  logic [AW-1:0]    head_q, tail_q;
  logic [WIDTH-1:0] q_pc    [DEPTH];
  logic [WIDTH-1:0] q_instr [DEPTH];

  logic accept, push, pop;
  logic redirect_unused;

  assign redirect_unused = ^redirect_pc[1:0];
  assign dbg_state       = state_q;

  // Occupancy alone limits issue: in FETCH nothing is outstanding, so occ_q is the full credit count.
  assign imem_req_valid = (state_q == S_FETCH) && (occ_q < CW'(DEPTH)) && !redirect_valid && !rst;
  assign imem_req_addr  = {fetch_pc_q[WIDTH-1:2], 2'b00};
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
  assign pop            = if_valid && if_ready && !redirect_valid;

  assign if_valid = (occ_q != '0);
  assign if_pc    = if_valid ? q_pc[head_q]    : '0;
  assign if_instr = if_valid ? q_instr[head_q] : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_resp_valid)     state_d = S_FETCH;
        else if (redirect_valid) state_d = S_DRAIN;
      end
      S_DRAIN: if (imem_resp_valid) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        fetch_pc_q <= {redirect_pc[WIDTH-1:2], 2'b00};
        occ_q      <= '0;
        head_q     <= '0;
        tail_q     <= '0;
      end else begin
        if (accept) begin
          fetch_pc_q <= fetch_pc_q + WIDTH'(4);
          req_pc_q   <= fetch_pc_q;
        end
        if (push) tail_q <= tail_q + AW'(1);
        if (pop)  head_q <= head_q + AW'(1);
        case ({push, pop})
          2'b10:   occ_q <= occ_q + CW'(1);
          2'b01:   occ_q <= occ_q - CW'(1);
          default: occ_q <= occ_q;
        endcase
      end
    end
  end

  // Queue storage needs no reset: entries are only visible while counted in occ_q.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc[tail_q]    <= req_pc_q;
      q_instr[tail_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with variable latency, a scoreboard of fetched PCs,
// directed multi-cycle sequences, a redirect vector table and a randomized phase.
module tb_fetch_unit;

  localparam int          WIDTH    = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic [1:0]  dbg_state;

  fetch_unit #(.WIDTH(WIDTH), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard and counters
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch;
  int n_tests = 0;
  int n_fail  = 0;

  // memory model state
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt  = 0;
  int          lat_fix  = 1;
  int          lat_max  = 3;
  logic        inject_resp = 1'b0;

  // per-cycle observations
  logic        last_acc, last_req_valid, last_pop;
  logic [31:0] last_addr, last_pop_pc;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_addr = '0;
  logic        rst_prev  = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  // One clock cycle: drive memory response, observe at negedge, update model, step past posedge.
  task automatic cycle();
    logic acc, pop;
    imem_resp_valid = inject_resp || (mem_pend && mem_cnt == 0);
    imem_resp_data  = inject_resp ? 32'hDEAD_BEEF : instr_of(mem_addr);
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    pop = if_valid && if_ready && !redirect_valid && !rst;
    last_acc = acc; last_addr = imem_req_addr; last_req_valid = imem_req_valid;
    last_pop = pop; last_pop_pc = if_pc;
    if (rst) begin
      if (rst_prev) begin
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
      end
    end else begin
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_fetch);
      if (hold_prev && !redirect_valid) begin
        check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
        check("req_hold_addr", imem_req_addr, hold_addr);
      end
      if (acc && mem_pend) fail("one_outstanding");
      if (pop) begin
        if (exp_q.size() == 0) fail("pop_unexpected");
        else begin
          check("pop_pc", if_pc, exp_q[0]);
          check("pop_instr", if_instr, instr_of(exp_q[0]));
        end
      end
    end
    // reference model update
    if (rst) begin
      exp_q.delete();
      exp_fetch = RESET_PC;
      mem_pend  = 1'b0;
    end else begin
      if (redirect_valid) begin
        exp_q.delete();
        exp_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back(imem_req_addr);
          exp_fetch = exp_fetch + 32'd4;
        end
      end
      if (imem_resp_valid && !inject_resp) mem_pend = 1'b0;
      else if (mem_pend && mem_cnt > 0) mem_cnt--;
      if (acc) begin
        mem_pend = 1'b1;
        mem_addr = imem_req_addr;
        mem_cnt  = (lat_fix != 0) ? lat_fix - 1 : int'($urandom_range(0, lat_max - 1));
      end
    end
    hold_prev = !rst && imem_req_valid && !imem_req_ready;
    hold_addr = imem_req_addr;
    rst_prev  = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; inject_resp = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_acc(input string name, output logic [31:0] addr);
    addr = '0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (last_acc) begin addr = last_addr; return; end
    end
    fail({name, "_timeout"});
  endtask

  task automatic wait_pop(input string name, output logic [31:0] pc);
    pc = '0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (last_pop) begin pc = last_pop_pc; return; end
    end
    fail({name, "_timeout"});
  endtask

  task automatic run(input int n, output int accs);
    accs = 0;
    for (int k = 0; k < n; k++) begin
      cycle();
      if (last_acc) accs++;
    end
  endtask

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } redir_vec_t;

  initial begin
    redir_vec_t  vecs[4];
    logic [31:0] a, p;
    int          accs;

    vecs[0] = '{32'h0000_0202, 32'h0000_0200, 32'h0000_0204};
    vecs[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h0000_0041, 32'h0000_0040, 32'h0000_0044};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    exp_fetch = RESET_PC;

    // reset release: first request in the first cycle, at RESET_PC
    do_reset();
    lat_fix = 1;
    cycle();
    check("first_req_valid", {31'b0, last_req_valid}, 32'd1);
    check("first_req_addr", last_addr, RESET_PC);

    // streaming order 0x0, 0x4, 0x8
    wait_pop("seq0", p); check("seq_pc0", p, 32'h0);
    wait_pop("seq1", p); check("seq_pc1", p, 32'h4);
    wait_pop("seq2", p); check("seq_pc2", p, 32'h8);

    // backpressure: queue fills to DEPTH and issue stops
    do_reset();
    if_ready = 1'b0;
    run(10, accs);
    check("fill_accepts", accs, DEPTH);
    check("fill_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("fill_if_valid", {31'b0, if_valid}, 32'd1);
    check("fill_if_pc", if_pc, RESET_PC);
    if_ready = 1'b1;
    run(12, accs);

    // memory stall: address held, queue drains, nothing accepted
    if_ready = 1'b0;
    run(10, accs);
    imem_req_ready = 1'b0; if_ready = 1'b1;
    run(5, accs);
    check("stall_accepts", accs, 0);
    check("stall_if_valid", {31'b0, if_valid}, 32'd0);
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    run(6, accs);

    // redirect while waiting on a slow response: drained, refetch at 0x100
    do_reset();
    lat_fix = 4;
    wait_acc("drain_acc0", a);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    redirect_valid = 1'b0;
    check("drain_state", {30'b0, dbg_state}, 32'd2);
    wait_acc("drain_acc1", a);
    check("drain_refetch_addr", a, 32'h0000_0100);
    wait_pop("drain_pop", p);
    check("drain_first_pc", p, 32'h0000_0100);

    // redirect coincident with the response: response dropped, refetch aligned
    do_reset();
    lat_fix = 1;
    wait_acc("coinc_acc0", a);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
    cycle();
    redirect_valid = 1'b0;
    wait_acc("coinc_acc1", a);
    check("coinc_refetch_addr", a, 32'h0000_0200);
    wait_pop("coinc_pop", p);
    check("coinc_first_pc", p, 32'h0000_0200);

    // reset mid-wait, stale response arrives after release
    do_reset();
    lat_fix = 6;
    wait_acc("rstw_acc0", a);
    cycle();
    do_reset();
    lat_fix = 1;
    inject_resp = 1'b1;
    cycle();
    inject_resp = 1'b0;
    check("rstw_req_addr", last_addr, RESET_PC);
    wait_pop("rstw_pop", p);
    check("rstw_first_pc", p, RESET_PC);

    // redirect vector table
    for (int i = 0; i < 4; i++) begin
      redirect_valid = 1'b1; redirect_pc = vecs[i].target;
      cycle();
      redirect_valid = 1'b0;
      wait_acc("vec_acc0", a);
      check($sformatf("vec%0d_addr", i), a, vecs[i].exp_addr);
      wait_acc("vec_acc1", a);
      check($sformatf("vec%0d_next", i), a, vecs[i].exp_next);
      run(8, accs);
    end

    // randomized traffic against the scoreboard
    lat_fix = 0; lat_max = 3;
    for (int i = 0; i < 4000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom_range(0, 4095);
      rst            = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
    run(20, accs);
    check("final_drain_accepts_nonzero", {31'b0, accs != 0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
